reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  32-entry general-purpose register file of the processor datapath; consumes the
//  32-bit write-back mux output (ALU result vs. memory data) as its write data.
//  Supplies two operands (rs, rt) to the decode/ALU stage and has one debug read port.
//  Optional write-to-read bypass removes the same-cycle write/read hazard.
// PARAMETERS
//  DATA_W  32  width of each register and of all data ports
//  ADDR_W  5   register index width; depth = 2**ADDR_W (32 entries)
//  BYPASS  1   1: a read of the register being written returns wr_data in the same cycle
//              0: the read returns the old (pre-edge) value
// PORTS
//  clk      in   1       clock; all writes on rising edge
//  reset    in   1       asynchronous, active-high; clears every register
//  rs_addr  in   ADDR_W  read port A index
//  rt_addr  in   ADDR_W  read port B index
//  rs_data  out  DATA_W  read port A data (combinational)
//  rt_data  out  DATA_W  read port B data (combinational)
//  wr_en    in   1       write enable from write-back control
//  wr_addr  in   ADDR_W  destination register index
//  wr_data  in   DATA_W  write data (write-back mux output)
//  dbg_addr in   ADDR_W  debug read index
//  dbg_data out  DATA_W  debug read data; never bypassed
// BEHAVIOUR
//  - Storage: array regs[0..2**ADDR_W-1] of DATA_W bits.
//  - Reset: reset=1 clears all entries to 0 immediately, without waiting for a clk edge.
//    While reset=1, rs_data = rt_data = dbg_data = 0 and writes are ignored, even with wr_en=1.
//    Deassertion takes effect at the next rising edge; the first write is at that edge.
//  - Write: at posedge clk with reset=0, wr_en=1 and wr_addr!=0: regs[wr_addr] <= wr_data.
//    Write latency is 1 cycle; the new value is readable from the array after the edge.
//  - Register 0 is hardwired to 0. Writes to index 0 are discarded.
//    Any read of index 0 returns 0 on all ports, including via bypass.
//  - Read: each of rs_data, rt_data and dbg_data is a pure function of its address and the
//    array, with no clock latency. Both operand ports may select the same index.
//  - Bypass (BYPASS=1): if wr_en=1, reset=0, wr_addr!=0 and rs_addr==wr_addr,
//    rs_data = wr_data. Same rule for rt_addr/rt_data, independently per port.
//    dbg_data always shows the array contents (the pre-edge value).
//  - Bypass disabled (BYPASS=0): rs_data and rt_data show array contents only.
//  - Simultaneous events:
//    - Read and write of the same index in one cycle follows the BYPASS rule.
//    - Reads of other indices are unaffected by the write.
//    - Only one write port exists, so write/write conflicts cannot occur.
//  - Reset asserted mid-cycle while wr_en=1: no write occurs and the array reads 0
//    from the moment reset rises.
//  - wr_data width is exactly DATA_W; no extension or truncation.
//  - No internal state other than the array; no FSM.
// TESTING
//  1 Reset: write 32'hfafafafa to r5, pulse reset between clk edges
//    -> dbg_data(r5) = 0 before the next edge.
//  2 Write/read: wr r3 = 32'h0f0f0f0f, then rs_addr=3, rt_addr=3
//    -> rs_data = rt_data = 32'h0f0f0f0f the cycle after the edge.
//  3 Zero register: wr_en=1, wr_addr=0, wr_data=32'hffffffff
//    -> rs_data(r0) = 0, both during the cycle and after the edge.
//  4 Bypass (BYPASS=1): r7 = 32'h00000001; same cycle wr r7 = 32'h12345678 and rs_addr=7
//    -> rs_data = 32'h12345678, dbg_data(r7) = 32'h00000001.
//    Repeat with BYPASS=0 -> rs_data = 32'h00000001.
//  5 Write during reset: reset=1, wr r9 = 32'hdeadbeef across 2 edges, release reset
//    -> r9 = 0.
//  6 Sweep: write i*32'h01010101 to r1..r31, read back on both ports
//    -> every value matches and r0 = 0.

Source files
------------

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry register file with two bypassable operand ports and a debug port
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic wr_live, byp_rs, byp_rt;
  assign wr_live = wr_en && !reset && (wr_addr != '0);
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (wr_live)
      regs[wr_addr] <= wr_data;
  always_comb begin
    byp_rs   = BYPASS && wr_live && (rs_addr == wr_addr);
    byp_rt   = BYPASS && wr_live && (rt_addr == wr_addr);
    rs_data  = (reset || rs_addr == '0) ? '0 : byp_rs ? wr_data : regs[rs_addr];
    rt_data  = (reset || rt_addr == '0) ? '0 : byp_rt ? wr_data : regs[rt_addr];
    dbg_data = (reset || dbg_addr == '0) ? '0 : regs[dbg_addr];
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed checks of reg_file_wb with bypass enabled and disabled
module tb_reg_file_wb;
  logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0, dbg_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rs1, rt1, dbg1, rs0, rt0, dbg0;
  int n_cmp = 0, n_bad = 0;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg1));
  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    edge_step();
    wr_en = 1'b0;
  endtask

  initial begin
    edge_step(); edge_step();
    #1;
    chk("rst_rs", rs1, '0); chk("rst_rt", rt1, '0); chk("rst_dbg", dbg1, '0);
    reset = 1'b0;
    // 1: asynchronous reset clears a written register before any edge
    wr(5'd5, 32'hfafafafa);
    dbg_addr = 5'd5; #1;
    chk("t1_pre", dbg1, 32'hfafafafa);
    reset = 1'b1; #1;
    chk("t1_rst_dbg", dbg1, '0);
    chk("t1_rst_dbg_n", dbg0, '0);
    reset = 1'b0; #1;
    chk("t1_after", dbg1, '0);
    edge_step();
    // 2: write then read on both operand ports
    wr(5'd3, 32'h0f0f0f0f);
    rs_addr = 5'd3; rt_addr = 5'd3; #1;
    chk("t2_rs", rs1, 32'h0f0f0f0f); chk("t2_rt", rt1, 32'h0f0f0f0f);
    chk("t2_rs_n", rs0, 32'h0f0f0f0f); chk("t2_rt_n", rt0, 32'h0f0f0f0f);
    // 3: register 0 is hardwired, including via bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hffffffff; rs_addr = 5'd0; dbg_addr = 5'd0; #1;
    chk("t3_during_b", rs1, '0); chk("t3_during_n", rs0, '0);
    edge_step();
    wr_en = 1'b0; #1;
    chk("t3_after_rs", rs1, '0); chk("t3_after_dbg", dbg1, '0);
    // 4: same-cycle write/read of r7
    wr(5'd7, 32'h00000001);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rs_addr = 5'd7; rt_addr = 5'd3; dbg_addr = 5'd7; #1;
    chk("t4_byp_rs", rs1, 32'h12345678);
    chk("t4_byp_dbg", dbg1, 32'h00000001);
    chk("t4_nobyp_rs", rs0, 32'h00000001);
    chk("t4_nobyp_dbg", dbg0, 32'h00000001);
    chk("t4_other_rt", rt1, 32'h0f0f0f0f);
    rt_addr = 5'd7; #1;
    chk("t4_byp_rt", rt1, 32'h12345678);
    chk("t4_nobyp_rt", rt0, 32'h00000001);
    edge_step();
    wr_en = 1'b0; #1;
    chk("t4_after_b", rs1, 32'h12345678); chk("t4_after_n", rs0, 32'h12345678);
    // 5: writes are ignored while reset is held
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hdeadbeef;
    rs_addr = 5'd9; dbg_addr = 5'd9; #1;
    chk("t5_byp_in_rst", rs1, '0);
    edge_step(); edge_step();
    chk("t5_in_rst", dbg1, '0);
    wr_en = 1'b0; reset = 1'b0;
    edge_step();
    chk("t5_r9_dbg", dbg1, '0); chk("t5_r9_rs", rs1, '0); chk("t5_r7", rt1, '0);
    // 6: sweep all registers
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i); dbg_addr = 5'(i); #1;
      chk($sformatf("t6_rs%0d", i), rs1, 32'(i) * 32'h01010101);
      chk($sformatf("t6_rt%0d", 31 - i), rt0, 32'(31 - i) * 32'h01010101);
      chk($sformatf("t6_dbg%0d", i), dbg0, 32'(i) * 32'h01010101);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
